fir_stim_source: RTL and testbench
==================================

# fir_stim_source

Test-stimulus transmitter that drives the 10-bit signed sample input of the team's 21-tap FIR filters. It generates one of several programmable waveforms (impulse, step, ramp, square, alternating) for a programmed number of samples. It then appends TAP-1 zero samples to flush the filter delay line. It sits upstream of the filter, paced by a system sample-enable strobe, and signals completion to the test controller.

## Interface
- WORD_SIZE, 10, sample width (two's complement)
- TAP, 21, filter length; flush emits TAP-1 zeros
- HOLD_W, 8, width of the square-wave half-period field
- LEN_W, 16, width of the sample-count field
- Reset is rst, synchronous, active-high; clock is clk.
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle request; ignored while busy=1
- mode  in  3  waveform select, latched on accepted start
- amplitude  in  WORD_SIZE  signed amplitude, latched on start
- length  in  LEN_W  number of waveform samples, latched on start
- hold  in  HOLD_W  square half-period in samples, latched on start
- sample_en  in  1  sample-rate strobe; one sample is emitted per high cycle in RUN/FLUSH
- sample_out  out  WORD_SIZE  signed sample, registered
- sample_valid  out  1  high for exactly one cycle per emitted sample
- busy  out  1  high in RUN, FLUSH, DONE
- done  out  1  one-cycle pulse at end of flush

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - busy=0 and sample_out=0.
  - On start=1, latch mode/amplitude/length/hold and clear the sample index k.
  - Go to RUN, or to FLUSH if length==0.
- RUN:
  - On each sample_en=1, emit waveform sample k and increment k.
  - After the length-th sample, go to FLUSH.
- FLUSH:
  - On each sample_en=1, emit 0.
  - After TAP-1 (20) samples, go to DONE.
- DONE: done=1 for one cycle, then return to IDLE.
- Waveforms (A = latched amplitude):
  - 0 impulse: A at k=0, else 0.
  - 1 step: A for every k.
  - 2 ramp: k truncated to WORD_SIZE; A ignored; wraps 511 -> -512.
  - 3 square: A for H samples, then -A for H samples, repeating. H = hold, with hold=0 treated as 1.
  - 4 alternating: +A at even k, -A at odd k.
  - 6, 7: reserved, emit 0.
  - 5: see Configuration.
- Negation is WORD_SIZE two's complement: -(-512) = -512 (wraps; no saturation).
- start while busy=1 is ignored, with no effect on latched fields.
- sample_en=0 stalls the generator with no state change. The stall can last arbitrarily long.
- Reset mid-operation aborts immediately: state goes to IDLE, no done pulse, outputs go to reset values.

## Timing
- Reset values: sample_out=0, sample_valid=0, busy=0, done=0; state IDLE.
- busy rises the cycle after the clock edge that samples start=1.
- Sample emission:
  - A sample is emitted on the clock edge that samples sample_en=1 in RUN/FLUSH.
  - sample_out and sample_valid update on that edge: one-cycle latency from sample_en.
- sample_en during the start-acceptance cycle is not used. The first sample requires sample_en=1 while in RUN.
- sample_out holds its last value between valids. It returns to 0 on entering IDLE.
- Transition to DONE happens on the edge emitting the last flush sample.
  - done=1 is asserted in the following cycle.
  - busy falls one cycle after that.
- With sample_en held high, a run takes length+20 consecutive valid cycles.
- Total start-to-done latency is length+22 cycles.

## Configuration
- FIR_STIM_LFSR_EN defined:
  - Mode 5 emits a pseudo-random WORD_SIZE-bit value from a Fibonacci LFSR, x^10+x^7+1.
  - The LFSR is seeded to 1 on accepted start and advances once per emitted RUN sample.
  - The first sample is the seed value (1).
- FIR_STIM_LFSR_EN undefined: no LFSR logic is built, and mode 5 emits 0 like the reserved modes.

## Test plan
- Impulse:
  - Stimulus: mode=0, A=21, length=1, sample_en=1 constantly.
  - Response: 21 valid samples, 21 then twenty 0s; done pulses once, 1 cycle after the 21st valid.
- Square:
  - Stimulus: mode=3, A=100, hold=3, length=12.
  - Response: 100,100,100,-100,-100,-100,100,100,100,-100,-100,-100, then 20 zeros.
- Ramp wrap and zero length:
  - Stimulus: mode=2, length=600.
  - Response: sample 511 is 511, sample 512 is -512, sample 599 is -425.
  - Stimulus: length=0.
  - Response: only 20 zeros, then done.
- Alternating negation edge:
  - Stimulus: mode=4, A=-512, length=4.
  - Response: -512 four times; A=5 gives 5,-5,5,-5.
- Pacing and start-while-busy:
  - Stimulus: sample_en high every 3rd cycle, mode=1, A=7, length=5; start pulsed mid-run with mode=0.
  - Response: valids spaced exactly 3 cycles apart, all 7; the second start is ignored.
- Reset mid-run:
  - Stimulus: assert rst after 3 samples of mode=1, length=10.
  - Response: the next cycle shows all outputs 0, no done pulse; a new start then runs normally from k=0.

Source files
------------

// File: rtl/fir_stim_source.sv
// Stimulus generator for the 21-tap FIR filters: emits a programmed waveform, then TAP-1 flush zeros.
// Optional LFSR waveform (mode 5) is built only when FIR_STIM_LFSR_EN is defined.
module fir_stim_source #(
  parameter int WORD_SIZE = 10,
  parameter int TAP       = 21,
  parameter int HOLD_W    = 8,
  parameter int LEN_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           mode,
  input  logic [WORD_SIZE-1:0] amplitude,
  input  logic [LEN_W-1:0]     length,
  input  logic [HOLD_W-1:0]    hold,
  input  logic                 sample_en,
  output logic [WORD_SIZE-1:0] sample_out,
  output logic                 sample_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int FCW = $clog2(TAP);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t               state, state_d;
  logic [2:0]           mode_q;
  logic [WORD_SIZE-1:0] amp_q;
  logic [LEN_W-1:0]     len_q;
  logic [HOLD_W-1:0]    hold_q;
  logic [LEN_W-1:0]     k;
  logic [FCW-1:0]       fcnt;
  logic [HOLD_W-1:0]    sq_cnt;
  logic                 sq_neg;
  logic [HOLD_W-1:0]    hmax;
  logic                 sq_last;
  logic [WORD_SIZE-1:0] neg_amp;
  logic [WORD_SIZE-1:0] wave;
  logic                 emit;
`ifdef FIR_STIM_LFSR_EN
  logic [WORD_SIZE-1:0] lfsr;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    neg_amp = -amp_q;
    hmax    = (hold_q == '0) ? HOLD_W'(1) : hold_q;
    sq_last = (sq_cnt == hmax - HOLD_W'(1));
    case (mode_q)
      3'd0:    wave = (k == '0) ? amp_q : '0;
      3'd1:    wave = amp_q;
      3'd2:    wave = k[WORD_SIZE-1:0];
      3'd3:    wave = sq_neg ? neg_amp : amp_q;
      3'd4:    wave = k[0] ? neg_amp : amp_q;
`ifdef FIR_STIM_LFSR_EN
      3'd5:    wave = lfsr;
`endif
      default: wave = '0;
    endcase
  end

  always_comb begin
    state_d = state;
    emit    = 1'b0;
    case (state)
      IDLE: if (start) state_d = (length == '0) ? FLUSH : RUN;
      RUN: if (sample_en) begin
        emit = 1'b1;
        if (k == len_q - LEN_W'(1)) state_d = FLUSH;
      end
      FLUSH: if (sample_en) begin
        emit = 1'b1;
        if (fcnt == FCW'(TAP - 2)) state_d = DONE;
      end
      // DONE spends one cycle raising done, then one cycle with done high before IDLE
      DONE: if (done) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
      mode_q       <= '0;
      amp_q        <= '0;
      len_q        <= '0;
      hold_q       <= '0;
      k            <= '0;
      fcnt         <= '0;
      sq_cnt       <= '0;
      sq_neg       <= 1'b0;
`ifdef FIR_STIM_LFSR_EN
      lfsr         <= WORD_SIZE'(1);
`endif
    end else begin
      state        <= state_d;
      sample_valid <= emit;
      done         <= (state == DONE) && !done;
      case (state)
        IDLE: begin
          sample_out <= '0;
          if (start) begin
            mode_q <= mode;
            amp_q  <= amplitude;
            len_q  <= length;
            hold_q <= hold;
            k      <= '0;
            fcnt   <= '0;
            sq_cnt <= '0;
            sq_neg <= 1'b0;
`ifdef FIR_STIM_LFSR_EN
            lfsr   <= WORD_SIZE'(1);
`endif
          end
        end
        RUN: if (sample_en) begin
          sample_out <= wave;
          k          <= k + LEN_W'(1);
          if (sq_last) begin
            sq_cnt <= '0;
            sq_neg <= !sq_neg;
          end else begin
            sq_cnt <= sq_cnt + HOLD_W'(1);
          end
`ifdef FIR_STIM_LFSR_EN
          lfsr <= {lfsr[WORD_SIZE-2:0], lfsr[9] ^ lfsr[6]};
`endif
        end
        FLUSH: if (sample_en) begin
          sample_out <= '0;
          fcnt       <= fcnt + FCW'(1);
        end
        DONE: if (done) sample_out <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_stim_source.sv
// Directed self-checking bench for fir_stim_source (default build; mode 5 expectations follow FIR_STIM_LFSR_EN).
module tb_fir_stim_source;

  logic        clk = 1'b0;
  logic        rst, start, sample_en;
  logic [2:0]  mode;
  logic [9:0]  amplitude;
  logic [15:0] length;
  logic [7:0]  hold;
  logic [9:0]  sample_out;
  logic        sample_valid, busy, done;

  int tests = 0;
  int fails = 0;

  logic [9:0] got[$];
  int         vidx[$];
  int         done_cnt, done_at, ncyc;

  always #5 clk = ~clk;

  fir_stim_source #(.WORD_SIZE(10), .TAP(21), .HOLD_W(8), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .amplitude(amplitude),
    .length(length), .hold(hold), .sample_en(sample_en), .sample_out(sample_out),
    .sample_valid(sample_valid), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start is applied for one cycle; sample_en is also high there and must be ignored.
  task automatic do_start(input logic [2:0] m, input logic [9:0] a, input logic [15:0] l, input logic [7:0] h);
    @(negedge clk);
    start = 1'b1; mode = m; amplitude = a; length = l; hold = h; sample_en = 1'b1;
    @(negedge clk);
    start = 1'b0; sample_en = 1'b0;
  endtask

  // Steps negedge by negedge until busy falls, recording valid samples and done pulses.
  task automatic collect(input int p, input int inj, input int budget);
    int n;
    got.delete(); vidx.delete();
    done_cnt = 0; done_at = -1; n = 0;
    sample_en = (p == 1);
    while (n < budget) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (sample_valid) begin
        got.push_back(sample_out);
        vidx.push_back(n);
      end
      if (done) begin
        done_cnt++;
        done_at = n;
      end
      if (!busy) break;
      sample_en = (p == 1) || (n % p == 0);
      if (inj != 0 && n == inj) begin
        start = 1'b1; mode = 3'd0; amplitude = 10'd99; length = 16'd3; hold = 8'd1;
      end
    end
    ncyc = n;
    sample_en = 1'b0;
    chk("busy_fell_within_budget", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int nz;
    int k;
    logic [9:0] sq_exp [12];
    rst = 1'b1; start = 1'b0; sample_en = 1'b0;
    mode = '0; amplitude = '0; length = '0; hold = '0;
    repeat (3) @(negedge clk);
    chk("reset_sample_out", {22'd0, sample_out}, 32'd0);
    chk("reset_valid", {31'd0, sample_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    // Impulse, A=21, length=1
    do_start(3'd0, 10'd21, 16'd1, 8'd0);
    chk("imp_busy_rise", {31'd0, busy}, 32'd1);
    chk("imp_no_valid_on_accept", {31'd0, sample_valid}, 32'd0);
    collect(1, 0, 100);
    chk("imp_count", got.size(), 32'd21);
    if (got.size() == 21) begin
      chk("imp_first", {22'd0, got[0]}, 32'd21);
      nz = 0;
      for (int i = 1; i < 21; i++) if (got[i] != 10'd0) nz++;
      chk("imp_flush_zeros", nz, 32'd0);
      chk("imp_first_valid_cycle", vidx[0], 32'd1);
      chk("imp_last_valid_cycle", vidx[20], 32'd21);
    end
    chk("imp_done_count", done_cnt, 32'd1);
    chk("imp_done_cycle", done_at, 32'd22);
    chk("imp_busy_fall_cycle", ncyc, 32'd23);
    chk("imp_idle_out", {22'd0, sample_out}, 32'd0);

    // Square, A=100, hold=3, length=12
    sq_exp = '{10'd100, 10'd100, 10'd100, 10'h39C, 10'h39C, 10'h39C,
               10'd100, 10'd100, 10'd100, 10'h39C, 10'h39C, 10'h39C};
    do_start(3'd3, 10'd100, 16'd12, 8'd3);
    collect(1, 0, 100);
    chk("sq_count", got.size(), 32'd32);
    if (got.size() == 32) begin
      for (int i = 0; i < 12; i++) chk($sformatf("sq_s%0d", i), {22'd0, got[i]}, {22'd0, sq_exp[i]});
      chk("sq_flush0", {22'd0, got[12]}, 32'd0);
    end

    // Square with hold=0 behaves as hold=1
    do_start(3'd3, 10'd1, 16'd4, 8'd0);
    collect(1, 0, 100);
    if (got.size() == 24) begin
      chk("sq0_s1", {22'd0, got[1]}, 32'h3FF);
      chk("sq0_s2", {22'd0, got[2]}, 32'd1);
    end else chk("sq0_count", got.size(), 32'd24);

    // Ramp wrap over length 600
    do_start(3'd2, 10'd77, 16'd600, 8'd0);
    collect(1, 0, 700);
    chk("ramp_count", got.size(), 32'd620);
    if (got.size() == 620) begin
      chk("ramp_s0", {22'd0, got[0]}, 32'd0);
      chk("ramp_s511", {22'd0, got[511]}, 32'd511);
      chk("ramp_s512", {22'd0, got[512]}, 32'h200);
      chk("ramp_s599", {22'd0, got[599]}, 32'd599);
      chk("ramp_flush", {22'd0, got[600]}, 32'd0);
    end
    chk("ramp_done_cycle", done_at, 32'd621);

    // Zero length goes straight to flush
    do_start(3'd1, 10'd50, 16'd0, 8'd0);
    collect(1, 0, 100);
    chk("zero_count", got.size(), 32'd20);
    nz = 0;
    foreach (got[i]) if (got[i] != 10'd0) nz++;
    chk("zero_all_zero", nz, 32'd0);
    chk("zero_done_count", done_cnt, 32'd1);
    chk("zero_done_cycle", done_at, 32'd21);

    // Alternating with A=-512 (negation wraps) and A=5
    do_start(3'd4, 10'h200, 16'd4, 8'd0);
    collect(1, 0, 100);
    if (got.size() == 24) begin
      for (int i = 0; i < 4; i++) chk($sformatf("alt512_s%0d", i), {22'd0, got[i]}, 32'h200);
    end else chk("alt512_count", got.size(), 32'd24);
    do_start(3'd4, 10'd5, 16'd4, 8'd0);
    collect(1, 0, 100);
    if (got.size() == 24) begin
      chk("alt5_s0", {22'd0, got[0]}, 32'd5);
      chk("alt5_s1", {22'd0, got[1]}, 32'h3FB);
      chk("alt5_s2", {22'd0, got[2]}, 32'd5);
      chk("alt5_s3", {22'd0, got[3]}, 32'h3FB);
    end else chk("alt5_count", got.size(), 32'd24);

    // Reserved modes
    do_start(3'd6, 10'd33, 16'd2, 8'd0);
    collect(1, 0, 100);
    if (got.size() == 22) chk("mode6_s0", {22'd0, got[0]}, 32'd0);
    else chk("mode6_count", got.size(), 32'd22);
    do_start(3'd5, 10'd33, 16'd4, 8'd0);
    collect(1, 0, 100);
    if (got.size() == 24) begin
`ifdef FIR_STIM_LFSR_EN
      chk("mode5_s0", {22'd0, got[0]}, 32'd1);
      chk("mode5_s3", {22'd0, got[3]}, 32'd8);
`else
      chk("mode5_s0", {22'd0, got[0]}, 32'd0);
      chk("mode5_s3", {22'd0, got[3]}, 32'd0);
`endif
    end else chk("mode5_count", got.size(), 32'd24);

    // Pacing every 3rd cycle with a start pulsed mid-run
    do_start(3'd1, 10'd7, 16'd5, 8'd0);
    collect(3, 5, 200);
    chk("pace_count", got.size(), 32'd25);
    if (got.size() == 25) begin
      chk("pace_first_cycle", vidx[0], 32'd4);
      nz = 0;
      for (int i = 0; i < 24; i++) if (vidx[i+1] - vidx[i] != 3) nz++;
      chk("pace_spacing", nz, 32'd0);
      nz = 0;
      for (int i = 0; i < 5; i++) if (got[i] != 10'd7) nz++;
      chk("pace_values", nz, 32'd0);
    end
    chk("pace_done_count", done_cnt, 32'd1);

    // Reset after 3 samples of a length-10 step
    do_start(3'd1, 10'd9, 16'd10, 8'd0);
    sample_en = 1'b1;
    nz = 0; k = 0;
    while (nz < 3 && k < 50) begin
      @(negedge clk);
      k++;
      if (sample_valid) nz++;
    end
    chk("rst_three_samples", nz, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_sample_out", {22'd0, sample_out}, 32'd0);
    chk("rst_valid", {31'd0, sample_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    nz = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || sample_valid) nz++;
    end
    chk("rst_no_done_or_valid", nz, 32'd0);
    sample_en = 1'b0;
    do_start(3'd0, 10'd3, 16'd2, 8'd0);
    collect(1, 0, 100);
    chk("rst_rerun_count", got.size(), 32'd22);
    if (got.size() == 22) begin
      chk("rst_rerun_s0", {22'd0, got[0]}, 32'd3);
      chk("rst_rerun_s1", {22'd0, got[1]}, 32'd0);
    end
    chk("rst_rerun_done", done_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
